// File: rtl/captura_pkg.sv
`default_nettype none
// ============================================================================
// Module  : captura_pkg
// Purpose : Shared types and constants for the captura_requisicoes stage.
// Revision: 1.0 - initial release
// ============================================================================
package captura_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        HOLD     = 3'd2,
        WAIT_REL = 3'd3,
        SYNC     = 3'd4
    } station_state_t;

    localparam logic [3:0] IDLE_HH       = 4'h0;
    localparam logic [1:0] IDLE_B        = 2'b11;
    localparam logic [1:0] KEYS_RELEASED = 2'b11;

    // Bits needed to hold values 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/captura_requisicoes_debounce.sv
`default_nettype none
// ============================================================================
// Module  : debounce_tecla
// Purpose : Two-flop synchronizer plus stable-time counter for one key bit.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_tecla
    import captura_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic OUT
);

    localparam int              CNT_W      = cnt_width(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    // Released (1) is the safe state for an active-low key.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_out  <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_meta <= IN;
            r_sync <= r_meta;
            if (r_sync == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt >= C_CNT_LAST) begin
                r_out <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign OUT = r_out;

endmodule
`default_nettype wire

// File: rtl/captura_requisicoes.sv
`default_nettype none
// ============================================================================
// Module  : captura_requisicoes
// Purpose : Debounces both stations' keys and latches each press as a request
//           held for HOLD_CYCLES. Optional macro PAIR_ALIGN_EN aligns captures.
// Revision: 1.0 - initial release
// ============================================================================
module captura_requisicoes
    import captura_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int ARM_CYCLES  = 2500000,
    parameter int HOLD_CYCLES = 250000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW0,
    input  logic [3:0] SW1,
    input  logic [1:0] KEY0,
    input  logic [1:0] KEY1,
    output logic [3:0] HH0,
    output logic [3:0] HH1,
    output logic [1:0] B0,
    output logic [1:0] B1,
    output logic       NEW0,
    output logic       NEW1,
    output logic       BUSY0,
    output logic       BUSY1
);

    localparam int               CNT_MAX     = (ARM_CYCLES > HOLD_CYCLES) ? ARM_CYCLES : HOLD_CYCLES;
    localparam int               CNT_W       = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] C_ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_SAT   = CNT_W'(CNT_MAX);

    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_sync;
    logic [3:0] w_key_raw;
    logic [3:0] w_dbk;
    logic [7:0] w_hh_bus;
    logic [3:0] w_b_bus;
    logic [1:0] w_new;
    logic [1:0] w_busy;
`ifdef PAIR_ALIGN_EN
    logic [1:0] w_in_arm;
    logic [1:0] w_arm_done;
`endif

    assign w_key_raw = {KEY1, KEY0};

    // Switches are only sampled at capture time, so synchronizing suffices.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= {SW1, SW0};
            r_sw_sync <= r_sw_meta;
        end
    end

    generate
        for (genvar gk = 0; gk < 4; gk++) begin : g_deb
            debounce_tecla #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .CLK(CLK),
                .RST(RST),
                .IN (w_key_raw[gk]),
                .OUT(w_dbk[gk])
            );
        end

        for (genvar gs = 0; gs < 2; gs++) begin : g_station
            station_state_t   r_state;
            station_state_t   w_state_nxt;
            logic [1:0]       w_dbk_st;
            logic [3:0]       w_sw_st;
            logic [1:0]       r_acc;
            logic [1:0]       w_acc_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic [CNT_W-1:0] w_cnt_inc;
            logic [3:0]       r_hh;
            logic [3:0]       w_hh_nxt;
            logic [1:0]       r_b;
            logic [1:0]       w_b_nxt;
            logic             r_new;
            logic             w_new_nxt;
            logic             r_busy;
            logic             w_capture;

            assign w_dbk_st  = w_dbk[gs*2 +: 2];
            assign w_sw_st   = r_sw_sync[gs*4 +: 4];
            assign w_cnt_inc = (r_cnt == C_CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef PAIR_ALIGN_EN
            logic w_peer_arm;
            logic w_peer_done;
            assign w_in_arm[gs]   = (r_state == ARM);
            assign w_arm_done[gs] = (r_state == ARM) && (r_cnt == C_ARM_LAST);
            assign w_peer_arm     = w_in_arm[1-gs];
            assign w_peer_done    = w_arm_done[1-gs];
`endif

            always_comb begin
                w_state_nxt = r_state;
                w_acc_nxt   = r_acc;
                w_cnt_nxt   = r_cnt;
                w_hh_nxt    = r_hh;
                w_b_nxt     = r_b;
                w_new_nxt   = 1'b0;
                w_capture   = 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_dbk_st != KEYS_RELEASED) begin
                            w_state_nxt = ARM;
                            w_acc_nxt   = w_dbk_st;
                            w_cnt_nxt   = '0;
                        end
                    end
                    ARM: begin
                        w_acc_nxt = r_acc & w_dbk_st;
                        w_cnt_nxt = w_cnt_inc;
                        if (r_cnt == C_ARM_LAST) begin
`ifdef PAIR_ALIGN_EN
                            // Wait for a peer still arming; simultaneous finishes capture together.
                            if (w_peer_arm && !w_peer_done) begin
                                w_state_nxt = SYNC;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_capture = 1'b1;
                            end
`else
                            w_capture = 1'b1;
`endif
                        end
                    end
                    HOLD: begin
                        w_cnt_nxt = w_cnt_inc;
                        if (r_cnt == C_HOLD_LAST) begin
                            w_hh_nxt    = IDLE_HH;
                            w_b_nxt     = IDLE_B;
                            w_cnt_nxt   = '0;
                            w_state_nxt = (w_dbk_st == KEYS_RELEASED) ? IDLE : WAIT_REL;
                        end
                    end
                    WAIT_REL: begin
                        if (w_dbk_st == KEYS_RELEASED) begin
                            w_state_nxt = IDLE;
                        end
                    end
`ifdef PAIR_ALIGN_EN
                    SYNC: begin
                        w_acc_nxt = r_acc & w_dbk_st;
                        if (w_peer_done || !w_peer_arm) begin
                            w_capture = 1'b1;
                        end
                    end
`endif
                    default: begin
                        w_state_nxt = IDLE;
                        w_hh_nxt    = IDLE_HH;
                        w_b_nxt     = IDLE_B;
                        w_cnt_nxt   = '0;
                    end
                endcase

                if (w_capture) begin
                    w_hh_nxt    = w_sw_st;
                    w_b_nxt     = r_acc & w_dbk_st;
                    w_new_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = HOLD;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_state <= IDLE;
                    r_acc   <= KEYS_RELEASED;
                    r_cnt   <= '0;
                    r_hh    <= IDLE_HH;
                    r_b     <= IDLE_B;
                    r_new   <= 1'b0;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_acc   <= w_acc_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_hh    <= w_hh_nxt;
                    r_b     <= w_b_nxt;
                    r_new   <= w_new_nxt;
                    r_busy  <= (w_state_nxt != IDLE);
                end
            end

            assign w_hh_bus[gs*4 +: 4] = r_hh;
            assign w_b_bus[gs*2 +: 2]  = r_b;
            assign w_new[gs]           = r_new;
            assign w_busy[gs]          = r_busy;
        end
    endgenerate

    assign HH0   = w_hh_bus[3:0];
    assign HH1   = w_hh_bus[7:4];
    assign B0    = w_b_bus[1:0];
    assign B1    = w_b_bus[3:2];
    assign NEW0  = w_new[0];
    assign NEW1  = w_new[1];
    assign BUSY0 = w_busy[0];
    assign BUSY1 = w_busy[1];

endmodule
`default_nettype wire

// File: doc/captura_requisicoes.md
Name: captura_requisicoes

Overview:
- Upstream input-capture stage for the two-station access-control core.
- Synchronizes and debounces the raw switches and push-buttons of both stations.
- Turns each press into one clean, latched request: 4-bit code plus 2-bit active-low function keys.
- Holds each request stable on the core's HH0/HH1/B0/B1 inputs for a fixed display time, then returns them to idle.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a key change (10 ms at 50 MHz).
- ARM_CYCLES, 2500000: window after the first key press during which further keys of the same station are accumulated.
- HOLD_CYCLES, 250000000: cycles a captured request is presented to the core (5 s at 50 MHz).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset: synchronous, active-high.
- SW0  in  4  raw station-0 switches, asynchronous.
- SW1  in  4  raw station-1 switches, asynchronous.
- KEY0  in  2  raw station-0 push-buttons, active-low.
- KEY1  in  2  raw station-1 push-buttons, active-low.
- HH0  out  4  latched station-0 code to core.
- HH1  out  4  latched station-1 code to core.
- B0  out  2  latched station-0 keys to core, active-low.
- B1  out  2  latched station-1 keys to core, active-low.
- NEW0  out  1  one-cycle pulse when station 0 presents a new request.
- NEW1  out  1  one-cycle pulse when station 1 presents a new request.
- BUSY0  out  1  station 0 not in IDLE.
- BUSY1  out  1  station 1 not in IDLE.

Behaviour:
- Clocking and reset
  - Single clock CLK. RST is synchronous and active-high.
  - Reset values: HH0=HH1=4'h0, B0=B1=2'b11, NEW*=0, BUSY*=0, all FSMs IDLE, all counters 0.
  - Debouncer outputs reset to released (1).
  - RST asserted mid-operation (ARM, HOLD or WAIT_REL) forces the reset values at the next edge. A key still held afterwards is treated as a new press once debounced.
- Input conditioning
  - All SW and KEY bits pass through a 2-flop synchronizer.
  - Each synchronized key feeds its own debouncer, producing dbk.
  - Debouncer: a counter increments while the synced input differs from the current output and clears when they match. When the count reaches DEB_CYCLES-1, the output toggles and the counter clears.
  - A glitch shorter than DEB_CYCLES never reaches dbk.
  - SW is synchronized only, not debounced.
- Per-station FSM (two independent instances)
  - IDLE: when dbk != 2'b11, go to ARM with acc<=dbk, cnt<=0.
  - ARM: each cycle acc<=acc&dbk, cnt++.
    - Capture happens in the cycle where cnt==ARM_CYCLES-1: HH<=synced SW, B<=acc&dbk, NEW=1 for exactly the next cycle, go to HOLD with cnt<=0.
    - Keys released inside the window still capture using acc. Presses accumulate; a pressed bit never reverts to 1.
  - HOLD: outputs stay frozen and new presses are ignored.
    - When cnt==HOLD_CYCLES-1: HH<=0 and B<=11.
    - Then go to IDLE if dbk==11, otherwise to WAIT_REL.
  - WAIT_REL: outputs idle; go to IDLE when dbk==11. This prevents a held key from re-triggering.
- Timing
  - BUSY = (state != IDLE), registered.
  - Latency, raw key edge to ARM entry: 2 + DEB_CYCLES + 1 cycles.
  - Latency, ARM entry to new HH/B: ARM_CYCLES cycles.
- Counter widths: $clog2(max count + 1). Counters saturate and never wrap.
- HH/B change only at capture and at hold expiry, so the combinational core sees a stable request for exactly HOLD_CYCLES cycles.

Optional Feature:
- Macro: PAIR_ALIGN_EN.
- Defined:
  - A station finishing its ARM window while the other station is in ARM enters a SYNC state. In SYNC the station keeps accumulating acc, and its outputs are frozen at their previous values.
  - Both stations capture on the same edge as the later one; both NEW pulses coincide and both HOLD timers start together.
  - SYNC is bounded by the other station's remaining ARM count, at most ARM_CYCLES.
- Undefined: stations are fully independent and there is no SYNC state.

Decomposition:
- Package captura_pkg holds:
  - state enum: IDLE, ARM, HOLD, WAIT_REL, SYNC.
  - IDLE_HH=4'h0, IDLE_B=2'b11.
  - KEYS_RELEASED=2'b11.
- Sub-module debounce_tecla: 2-flop synchronizer plus stable counter, parameter DEB_CYCLES, ports CLK/RST/IN/OUT. Instantiated 4 times.
- The station FSM stays inline, replicated twice by a generate loop.

Test Plan (DEB_CYCLES=4, ARM_CYCLES=8, HOLD_CYCLES=16):
- Reset: assert RST 3 cycles with KEY0=KEY1=11 -> HH0=HH1=0, B0=B1=11, BUSY0=BUSY1=0, NEW0=NEW1=0.
- Single press: SW0=1011, KEY0=10 held 40 cycles -> HH0=1011, B0=10 and one NEW0 pulse. Outputs hold 16 cycles, then return to 0/11. BUSY0 stays 1 in WAIT_REL until KEY0=11.
- Staggered keys: KEY1[1] low, then KEY1[0] low 3 cycles later, both held -> B1=00 captured with a single NEW1 pulse.
- Bounce: KEY0[0] low for 2 cycles only -> no ARM, BUSY0=0, outputs unchanged.
- Reset during HOLD: RST at HOLD cycle 5 -> next edge HH0=0, B0=11, BUSY0=0. No NEW0 pulse after RST deasserts until a fresh debounced press.
- Pair alignment: station 0 arms 5 cycles before station 1 -> with PAIR_ALIGN_EN, NEW0 and NEW1 pulse on the same cycle; without it, 5 cycles apart.
